// File: rtl/control_unit_if.sv
// Datapath control bundle: instruction/memory status in, every datapath strobe out.
interface control_unit_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic HIin, HIout, LOin, LOout;
    logic Zhighin, Zlowin, Zhighout, Zlowout;
    logic PCin, PCout, MARin, MDRin, MDRout, IRin, CSEout, Yin;
    logic MDMuxread;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC;
    logic mem_read, mem_write;
    logic run;

    // Sequencer side
    modport master (
        input  ir, mem_ready,
        output Rin, Rout, HIin, HIout, LOin, LOout,
               Zhighin, Zlowin, Zhighout, Zlowout,
               PCin, PCout, MARin, MDRin, MDRout, IRin, CSEout, Yin, MDMuxread,
               ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC,
               mem_read, mem_write, run
    );

    // Datapath side
    modport slave (
        output ir, mem_ready,
        input  Rin, Rout, HIin, HIout, LOin, LOout,
               Zhighin, Zlowin, Zhighout, Zlowout,
               PCin, PCout, MARin, MDRin, MDRout, IRin, CSEout, Yin, MDMuxread,
               ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC,
               mem_read, mem_write, run
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired T-state sequencer for the 32-bit bus datapath.
// State, wait counter and the latched IR fields are registered; strobes are
// Moore-decoded from them, except MDRin which follows mem_ready in read waits.
module control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clock,
    input  logic          clear,
    control_unit_if.master bus
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                           OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                           OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000,
                           OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011,
                           OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                           OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001,
                           OP_NOT  = 5'b10010, OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_RT, C_IMM, C_LD, C_ST, C_MD, C_UN, C_HALT
    } cls_t;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic [31:15]  ir_q;
    logic [31:15]  ire;
    logic [4:0]    opc;
    logic [3:0]    ra, rb, rc;
    cls_t          cls;
    logic          wlast;
    logic          op_en;
    logic          ir_unused;

    // The constant field goes to the datapath through CSEout; nothing here reads it.
    assign ir_unused = ^bus.ir[14:0];

    // Decode straight from the IR bus in T3 (the datapath IR just loaded),
    // from the latched copy afterwards.
    assign ire   = (state == S_T3) ? bus.ir[31:15] : ir_q;
    assign opc   = ire[31:27];
    assign ra    = ire[26:23];
    assign rb    = ire[22:19];
    assign rc    = ire[18:15];
    assign wlast = (wcnt == CW'(MEM_TIMEOUT - 1));

    // Instruction class selects the T-state path.
    always_comb begin
        cls = C_NOP;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:         cls = C_RT;
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: cls = C_IMM;
            OP_LD:                           cls = C_LD;
            OP_ST:                           cls = C_ST;
            OP_MUL, OP_DIV:                  cls = C_MD;
            OP_NEG, OP_NOT:                  cls = C_UN;
            OP_HALT:                         cls = C_HALT;
            default:                         cls = C_NOP;
        endcase
    end

    // T-state sequencing; the wait counter is zero on entry to every wait state.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_RST;
            wcnt  <= '0;
            ir_q  <= '0;
        end else begin
            wcnt <= '0;
            case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1: begin
                    if (bus.mem_ready)  state <= S_T2;
                    else if (wlast)     state <= S_HALT;
                    else                wcnt  <= wcnt + 1'b1;
                end
                S_T2:  state <= S_T3;
                S_T3: begin
                    ir_q <= bus.ir[31:15];
                    case (cls)
                        C_NOP:   state <= S_T0;
                        C_HALT:  state <= S_HALT;
                        default: state <= S_T4;
                    endcase
                end
                S_T4:  state <= (cls == C_UN) ? S_T0 : S_T5;
                S_T5:  state <= (cls == C_RT || cls == C_IMM) ? S_T0 : S_T6;
                S_T6: begin
                    if (cls == C_LD) begin
                        if (bus.mem_ready)  state <= S_T7;
                        else if (wlast)     state <= S_HALT;
                        else                wcnt  <= wcnt + 1'b1;
                    end else if (cls == C_ST) begin
                        state <= S_T7;
                    end else begin
                        state <= S_T0;
                    end
                end
                S_T7: begin
                    if (cls != C_ST)        state <= S_T0;
                    else if (bus.mem_ready) state <= S_T0;
                    else if (wlast)         state <= S_HALT;
                    else                    wcnt  <= wcnt + 1'b1;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Strobe decode per state and instruction class.
    always_comb begin
        bus.Rin = '0;       bus.Rout = '0;
        bus.HIin = 1'b0;    bus.HIout = 1'b0;   bus.LOin = 1'b0;    bus.LOout = 1'b0;
        bus.Zhighin = 1'b0; bus.Zlowin = 1'b0;  bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
        bus.PCin = 1'b0;    bus.PCout = 1'b0;   bus.MARin = 1'b0;   bus.MDRin = 1'b0;
        bus.MDRout = 1'b0;  bus.IRin = 1'b0;    bus.CSEout = 1'b0;  bus.Yin = 1'b0;
        bus.MDMuxread = 1'b0;
        bus.ADD = 1'b0; bus.SUB = 1'b0; bus.MUL = 1'b0; bus.DIV = 1'b0;
        bus.AND = 1'b0; bus.OR = 1'b0;  bus.SHR = 1'b0; bus.SHRA = 1'b0;
        bus.SHL = 1'b0; bus.ROR = 1'b0; bus.ROL = 1'b0; bus.NEG = 1'b0;
        bus.NOT = 1'b0; bus.IncPC = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.run = (state != S_RST) && (state != S_HALT);
        op_en = 1'b0;
        case (state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.mem_read = 1'b1;
                bus.MDMuxread = 1'b1; bus.MDRin = bus.mem_ready;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_RT, C_IMM, C_LD, C_ST: begin bus.Rout = 16'd1 << rb; bus.Yin = 1'b1; end
                    C_MD: begin bus.Rout = 16'd1 << ra; bus.Yin = 1'b1; end
                    C_UN: begin bus.Rout = 16'd1 << rb; op_en = 1'b1; bus.Zlowin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_RT: begin bus.Rout = 16'd1 << rc; op_en = 1'b1; bus.Zlowin = 1'b1; end
                    C_IMM, C_LD, C_ST: begin bus.CSEout = 1'b1; op_en = 1'b1; bus.Zlowin = 1'b1; end
                    C_MD: begin
                        bus.Rout = 16'd1 << rb; op_en = 1'b1;
                        bus.Zhighin = 1'b1; bus.Zlowin = 1'b1;
                    end
                    C_UN: begin bus.Zlowout = 1'b1; bus.Rin = 16'd1 << ra; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_RT, C_IMM: begin bus.Zlowout = 1'b1; bus.Rin = 16'd1 << ra; end
                    C_LD, C_ST:  begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
                    C_MD:        begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        bus.mem_read = 1'b1; bus.MDMuxread = 1'b1; bus.MDRin = bus.mem_ready;
                    end
                    C_ST: begin bus.Rout = 16'd1 << ra; bus.MDRin = 1'b1; end
                    C_MD: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin bus.MDRout = 1'b1; bus.Rin = 16'd1 << ra; end
                    C_ST: begin bus.MDRout = 1'b1; bus.mem_write = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (op_en) begin
            case (opc)
                OP_ADD, OP_ADDI, OP_LDI, OP_LD, OP_ST: bus.ADD = 1'b1;
                OP_SUB:           bus.SUB  = 1'b1;
                OP_AND, OP_ANDI:  bus.AND  = 1'b1;
                OP_OR, OP_ORI:    bus.OR   = 1'b1;
                OP_ROR:           bus.ROR  = 1'b1;
                OP_ROL:           bus.ROL  = 1'b1;
                OP_SHR:           bus.SHR  = 1'b1;
                OP_SHRA:          bus.SHRA = 1'b1;
                OP_SHL:           bus.SHL  = 1'b1;
                OP_MUL:           bus.MUL  = 1'b1;
                OP_DIV:           bus.DIV  = 1'b1;
                OP_NEG:           bus.NEG  = 1'b1;
                OP_NOT:           bus.NOT  = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe tables for each instruction class.
module tb_control_unit;
    localparam int MT = 12;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    control_unit_if b();
    control_unit #(.MEM_TIMEOUT(MT)) dut (.clock(clock), .clear(clear), .bus(b));

    // Single-bit strobe positions in the flags() vector
    localparam logic [33:0] RUN = 34'h1 << 0,  MWR = 34'h1 << 1,  MRD = 34'h1 << 2,
                            INC = 34'h1 << 3,  NOTm = 34'h1 << 4, NEGm = 34'h1 << 5,
                            ROLm = 34'h1 << 6, RORm = 34'h1 << 7, SHLm = 34'h1 << 8,
                            SHRAm = 34'h1 << 9, SHRm = 34'h1 << 10, ORm = 34'h1 << 11,
                            ANDm = 34'h1 << 12, DIVm = 34'h1 << 13, MULm = 34'h1 << 14,
                            SUBm = 34'h1 << 15, ADDm = 34'h1 << 16, MUX = 34'h1 << 17,
                            YIN = 34'h1 << 18, CSE = 34'h1 << 19, IRIN = 34'h1 << 20,
                            MDROUT = 34'h1 << 21, MDRIN = 34'h1 << 22, MARIN = 34'h1 << 23,
                            PCOUT = 34'h1 << 24, PCIN = 34'h1 << 25, ZLOUT = 34'h1 << 26,
                            ZHOUT = 34'h1 << 27, ZLIN = 34'h1 << 28, ZHIN = 34'h1 << 29,
                            LOOUT = 34'h1 << 30, LOIN = 34'h1 << 31, HIOUT = 34'h1 << 32,
                            HIIN = 34'h1 << 33;

    localparam logic [33:0] T0F = PCOUT | MARIN | INC | ZLIN | RUN;
    localparam logic [33:0] T1R = ZLOUT | PCIN | MRD | MUX | MDRIN | RUN;
    localparam logic [33:0] T1W = ZLOUT | PCIN | MRD | MUX | RUN;
    localparam logic [33:0] T2F = MDROUT | IRIN | RUN;

    function automatic logic [33:0] flags();
        return {b.HIin, b.HIout, b.LOin, b.LOout, b.Zhighin, b.Zlowin, b.Zhighout, b.Zlowout,
                b.PCin, b.PCout, b.MARin, b.MDRin, b.MDRout, b.IRin, b.CSEout, b.Yin,
                b.MDMuxread, b.ADD, b.SUB, b.MUL, b.DIV, b.AND, b.OR, b.SHR, b.SHRA, b.SHL,
                b.ROR, b.ROL, b.NEG, b.NOT, b.IncPC, b.mem_read, b.mem_write, b.run};
    endfunction

    task automatic do_reset();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        b.ir = 32'h0; b.mem_ready = 1'b1;
        clear = 1'b1;
        @(posedge clock); #1;
        total++;
        if (flags() !== 34'h0 || b.Rin !== 16'h0 || b.Rout !== 16'h0)
            $display("FAIL reset_hold flags=%h Rin=%h Rout=%h want 0", flags(), b.Rin, b.Rout);
        else passed++;
        clear = 1'b0;
        @(posedge clock); #1;
        total++;
        if (flags() !== T0F) $display("FAIL reset_t0 flags=%h want %h", flags(), T0F);
        else passed++;
    endtask

    task automatic test_add();
        logic [33:0] ef [7];
        logic [15:0] ri [7];
        logic [15:0] ro [7];
        ef = '{T0F, T1R, T2F, YIN | RUN, ADDm | ZLIN | RUN, ZLOUT | RUN, T0F};
        ri = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0008, 16'h0};
        ro = '{16'h0, 16'h0, 16'h0, 16'h0002, 16'h0004, 16'h0, 16'h0};
        b.ir = 32'hFFFF_FFFF; b.mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #2;
            total++;
            if (flags() !== ef[i] || b.Rin !== ri[i] || b.Rout !== ro[i])
                $display("FAIL add_c%0d flags=%h Rin=%h Rout=%h want %h %h %h",
                         i, flags(), b.Rin, b.Rout, ef[i], ri[i], ro[i]);
            else passed++;
            // IR only becomes meaningful once the datapath has loaded it
            if (i == 2) b.ir = 32'h1989_0000;
        end
    endtask

    task automatic test_reset_mid();
        b.ir = 32'h1989_0000; b.mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
        end
        total++;
        if (flags() !== (ADDm | ZLIN | RUN) || b.Rout !== 16'h0004)
            $display("FAIL mid_t4 flags=%h Rout=%h want %h 0004", flags(), b.Rout, ADDm | ZLIN | RUN);
        else passed++;
        #2 clear = 1'b1;
        #1;
        total++;
        if (flags() !== 34'h0 || b.Rin !== 16'h0 || b.Rout !== 16'h0)
            $display("FAIL mid_clear flags=%h Rin=%h Rout=%h want 0", flags(), b.Rin, b.Rout);
        else passed++;
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock); #1;
        total++;
        if (flags() !== T0F) $display("FAIL mid_t0 flags=%h want %h", flags(), T0F);
        else passed++;
    endtask

    task automatic test_ld();
        logic [33:0] ef [12];
        logic [15:0] ri [12];
        logic [15:0] ro [12];
        logic        mr [12];
        ef = '{T0F, T1R, T2F, YIN | RUN, CSE | ADDm | ZLIN | RUN, ZLOUT | MARIN | RUN,
               MRD | MUX | RUN, MRD | MUX | RUN, MRD | MUX | RUN, MRD | MUX | MDRIN | RUN,
               MDROUT | RUN, T0F};
        ri = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0};
        ro = '{16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        b.ir = 32'h0200_0055;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            b.mem_ready = mr[i];
            #1;
            total++;
            if (flags() !== ef[i] || b.Rin !== ri[i] || b.Rout !== ro[i])
                $display("FAIL ld_c%0d flags=%h Rin=%h Rout=%h want %h %h %h",
                         i, flags(), b.Rin, b.Rout, ef[i], ri[i], ro[i]);
            else passed++;
        end
    endtask

    task automatic test_st();
        logic [33:0] ef [10];
        logic [15:0] ro [10];
        logic        mr [10];
        ef = '{T0F, T1R, T2F, YIN | RUN, CSE | ADDm | ZLIN | RUN, ZLOUT | MARIN | RUN,
               MDRIN | RUN, MDROUT | MWR | RUN, MDROUT | MWR | RUN, T0F};
        ro = '{16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0010, 16'h0, 16'h0, 16'h0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b.ir = 32'h1200_0055;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            b.mem_ready = mr[i];
            #1;
            total++;
            if (flags() !== ef[i] || b.Rin !== 16'h0 || b.Rout !== ro[i])
                $display("FAIL st_c%0d flags=%h Rin=%h Rout=%h want %h 0000 %h",
                         i, flags(), b.Rin, b.Rout, ef[i], ro[i]);
            else passed++;
        end
    endtask

    task automatic test_mul();
        logic [33:0] ef [8];
        logic [15:0] ro [8];
        ef = '{T0F, T1R, T2F, YIN | RUN, MULm | ZHIN | ZLIN | RUN, ZLOUT | LOIN | RUN,
               ZHOUT | HIIN | RUN, T0F};
        ro = '{16'h0, 16'h0, 16'h0, 16'h0020, 16'h0040, 16'h0, 16'h0, 16'h0};
        b.ir = 32'h82B0_0000; b.mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #2;
            total++;
            if (flags() !== ef[i] || b.Rin !== 16'h0 || b.Rout !== ro[i])
                $display("FAIL mul_c%0d flags=%h Rin=%h Rout=%h want %h 0000 %h",
                         i, flags(), b.Rin, b.Rout, ef[i], ro[i]);
            else passed++;
        end
    endtask

    task automatic test_neg();
        logic [33:0] ef [7];
        logic [15:0] ri [7];
        logic [15:0] ro [7];
        logic        mr [7];
        ef = '{T0F, T1W, T1R, T2F, NEGm | ZLIN | RUN, ZLOUT | RUN, T0F};
        ri = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0};
        ro = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h0, 16'h0};
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        b.ir = 32'h8890_0000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clock); #1;
            b.mem_ready = mr[i];
            #1;
            total++;
            if (flags() !== ef[i] || b.Rin !== ri[i] || b.Rout !== ro[i])
                $display("FAIL neg_c%0d flags=%h Rin=%h Rout=%h want %h %h %h",
                         i, flags(), b.Rin, b.Rout, ef[i], ri[i], ro[i]);
            else passed++;
        end
    endtask

    task automatic test_halt();
        int bad;
        logic [33:0] ef [4];
        ef = '{T0F, T1R, T2F, RUN};
        b.ir = 32'hD800_0000; b.mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #2;
            total++;
            if (flags() !== ef[i]) $display("FAIL halt_c%0d flags=%h want %h", i, flags(), ef[i]);
            else passed++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            b.mem_ready = 1'($urandom_range(1));
            #1;
            if (flags() !== 34'h0 || b.Rin !== 16'h0 || b.Rout !== 16'h0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL halt_hold bad_cycles=%0d want 0", bad);
        else passed++;
        b.ir = 32'h1989_0000;
        do_reset();
        @(posedge clock); #2;
        total++;
        if (flags() !== T0F) $display("FAIL halt_clear flags=%h want %h", flags(), T0F);
        else passed++;
    endtask

    task automatic test_timeout();
        int bad;
        b.ir = 32'h1989_0000; b.mem_ready = 1'b0;
        do_reset();
        @(posedge clock); #2;
        total++;
        if (flags() !== T0F) $display("FAIL to_t0 flags=%h want %h", flags(), T0F);
        else passed++;
        bad = 0;
        for (int i = 0; i < MT; i++) begin
            @(posedge clock); #2;
            if (flags() !== T1W) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL to_wait bad_cycles=%0d want 0 (flags=%h)", bad, flags());
        else passed++;
        @(posedge clock); #2;
        total++;
        if (flags() !== 34'h0) $display("FAIL to_halt flags=%h want 0", flags());
        else passed++;
        b.mem_ready = 1'b1;
        @(posedge clock); #2;
        total++;
        if (flags() !== 34'h0) $display("FAIL to_stay flags=%h want 0", flags());
        else passed++;
    endtask

    initial begin
        b.ir = 32'h0;
        b.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_reset_mid();
        test_ld();
        test_st();
        test_mul();
        test_neg();
        test_halt();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
